// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing (sync, de, x/y, frame_start) gated by a qualified PLL lock
//   clk_i           pixel clock (PLL clkout)
//   rst_ni          asynchronous active-low reset
//   pll_lock_i      PLL lock, asynchronous to clk_i
//   hsync_o/vsync_o sync outputs, HS_POL/VS_POL level when active
//   de_o            high during active pixels
//   x_o/y_o         horizontal/vertical counters (0 when idle)
//   frame_start_o   one-cycle pulse at (0,0)
//   running_o       high while generating timing
module video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int LOCK_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        pll_lock_i,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        de_o,
  output logic [11:0] x_o,
  output logic [11:0] y_o,
  output logic        frame_start_o,
  output logic        running_o
);
  localparam logic [12:0] H_ACT   = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG  = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END  = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] H_LAST  = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [12:0] V_ACT   = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG  = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END  = 13'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [12:0] V_LAST  = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam int          CW      = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    sync_q;
  logic [CW-1:0] qual_q, qual_d;
  logic [11:0]   h_q, h_d, v_q, v_d;
  logic          lock_s, h_wrap, run_d;

  assign lock_s    = sync_q[1];
  assign run_d     = state_d == RUN;
  assign x_o       = h_q;
  assign y_o       = v_q;
  assign running_o = state_q == RUN;

  // Counters are cleared whenever the next state is not RUN, so a lock loss or a
  // fresh qualification always restarts the raster at (0,0).
  always_comb begin
    state_d = state_q;
    qual_d  = '0;
    h_d     = '0;
    v_d     = '0;
    h_wrap  = 1'b0;
    if (!lock_s) state_d = WAIT_LOCK;
    else if (state_q == WAIT_LOCK) begin
      state_d = (qual_q == LOCK_LAST) ? RUN : WAIT_LOCK;
      qual_d  = (qual_q == LOCK_LAST) ? '0 : qual_q + CW'(1);
    end else begin
      h_wrap = {1'b0, h_q} == H_LAST;
      h_d    = h_wrap ? '0 : h_q + 12'd1;
      v_d    = !h_wrap ? v_q : ({1'b0, v_q} == V_LAST) ? '0 : v_q + 12'd1;
    end
  end

  // Sync/de/frame_start are decoded from the next counter values so they stay
  // aligned with x_o/y_o, which come straight from the counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q        <= '0;
      state_q       <= WAIT_LOCK;
      qual_q        <= '0;
      h_q           <= '0;
      v_q           <= '0;
      hsync_o       <= ~HS_POL;
      vsync_o       <= ~VS_POL;
      de_o          <= 1'b0;
      frame_start_o <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], pll_lock_i};
      state_q       <= state_d;
      qual_q        <= qual_d;
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_o       <= (run_d && {1'b0, h_d} >= HS_BEG && {1'b0, h_d} < HS_END) ? HS_POL : ~HS_POL;
      vsync_o       <= (run_d && {1'b0, v_d} >= VS_BEG && {1'b0, v_d} < VS_END) ? VS_POL : ~VS_POL;
      de_o          <= run_d && {1'b0, h_d} < H_ACT && {1'b0, v_d} < V_ACT;
      frame_start_o <= run_d && h_d == '0 && v_d == '0;
    end
  end
endmodule
